// File: rtl/usbhost_link_ctrl.sv
// USB host link signalling: bus reset, resume, suspend, 1 ms SOF requests with frame numbering.
// Optional remote-wakeup K detection while suspended, enabled by defining USBHOST_REMOTE_WAKE_EN.
module usbhost_link_ctrl #(
    parameter int ResetUs        = 10000,
    parameter int RecovUs        = 10,
    parameter int ResumeUs       = 20000,
    parameter int SofPeriodUs    = 1000,
    parameter int WakeFiltCycles = 32
) (
    input  logic        clk_48mhz_i,
    input  logic        rst_ni,
    input  logic        us_tick_i,
    input  logic        enable_i,
    input  logic        reset_req_i,
    input  logic        suspend_req_i,
    input  logic        resume_req_i,
    input  logic        usb_dp_i,
    input  logic        usb_dn_i,
    input  logic        sof_ack_i,
    output logic        usb_dp_o,
    output logic        usb_dn_o,
    output logic        usb_oe_o,
    output logic        sof_req_o,
    output logic [10:0] frame_num_o,
    output logic        sof_overrun_o,
    output logic        wake_det_o,
    output logic [2:0]  link_state_o
);

    typedef enum logic [2:0] {
        ST_DISABLED    = 3'd0,
        ST_BUS_RESET   = 3'd1,
        ST_RESET_RECOV = 3'd2,
        ST_ACTIVE      = 3'd3,
        ST_SUSPENDED   = 3'd4,
        ST_RESUME_K    = 3'd5,
        ST_RESUME_EOP  = 3'd6
    } state_t;

    localparam logic [14:0] LP_RESET_LAST  = 15'(ResetUs - 1);
    localparam logic [14:0] LP_RECOV_LAST  = 15'(RecovUs - 1);
    localparam logic [14:0] LP_RESUME_LAST = 15'(ResumeUs - 1);
    localparam logic [14:0] LP_SOF_LAST    = 15'(SofPeriodUs - 1);
    localparam logic [14:0] LP_EOP_J_START = 15'd64;
    localparam logic [14:0] LP_EOP_LAST    = 15'd71;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [14:0] r_timer;
    logic [14:0] w_timer_nxt;
    logic [14:0] r_sof_tmr;
    logic [10:0] r_frame;
    logic        r_sof_req;
    logic        r_sof_ovr;
    logic        r_wake_det;
    logic        r_oe;
    logic        r_dp;
    logic        r_dn;
    logic        w_enter;
    logic        w_wake;
    logic        w_sof_run;
    logic        w_sof_expire;
    logic        w_sof_ack;

`ifdef USBHOST_REMOTE_WAKE_EN
    localparam int WW = $clog2(WakeFiltCycles + 1);
    localparam logic [WW-1:0] LP_WAKE_LAST = WW'(WakeFiltCycles - 1);

    logic [WW-1:0] r_wake_cnt;
    logic          w_line_k;

    assign w_line_k = ~usb_dp_i & usb_dn_i;
    assign w_wake   = (r_state == ST_SUSPENDED) && w_line_k && (r_wake_cnt == LP_WAKE_LAST);

    // Any non-K sample, or leaving Suspended, restarts the stability count
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wake_cnt <= '0;
        end else if ((r_state != ST_SUSPENDED) || !w_line_k) begin
            r_wake_cnt <= '0;
        end else if (r_wake_cnt != LP_WAKE_LAST) begin
            r_wake_cnt <= r_wake_cnt + WW'(1);
        end
    end
`else
    localparam int LP_UNUSED_WAKE_FILT = WakeFiltCycles;
    logic w_unused_line;

    assign w_unused_line = usb_dp_i ^ usb_dn_i;
    assign w_wake        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (!enable_i) begin
            w_state_nxt = ST_DISABLED;
        end else if (reset_req_i) begin
            w_state_nxt = ST_BUS_RESET;
        end else begin
            case (r_state)
                ST_DISABLED:    w_state_nxt = ST_DISABLED;
                ST_BUS_RESET:   if (us_tick_i && (r_timer == LP_RESET_LAST)) w_state_nxt = ST_RESET_RECOV;
                ST_RESET_RECOV: if (us_tick_i && (r_timer == LP_RECOV_LAST)) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE:      if (suspend_req_i) w_state_nxt = ST_SUSPENDED;
                ST_SUSPENDED:   if (resume_req_i || w_wake) w_state_nxt = ST_RESUME_K;
                ST_RESUME_K:    if (us_tick_i && (r_timer == LP_RESUME_LAST)) w_state_nxt = ST_RESUME_EOP;
                ST_RESUME_EOP:  if (r_timer == LP_EOP_LAST) w_state_nxt = ST_ACTIVE;
                default:        w_state_nxt = ST_DISABLED;
            endcase
        end
    end

    // A reset request re-enters BusReset even when already there, so it counts as an entry
    assign w_enter = (w_state_nxt != r_state) || (enable_i && reset_req_i);

    always_comb begin
        w_timer_nxt = r_timer;
        if (w_enter) begin
            w_timer_nxt = '0;
        end else if (r_state == ST_RESUME_EOP) begin
            w_timer_nxt = r_timer + 15'd1;
        end else if (us_tick_i && ((r_state == ST_BUS_RESET) || (r_state == ST_RESET_RECOV) ||
                                   (r_state == ST_RESUME_K))) begin
            w_timer_nxt = r_timer + 15'd1;
        end
    end

    assign w_sof_run    = (r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE);
    assign w_sof_expire = w_sof_run && us_tick_i && (r_sof_tmr == LP_SOF_LAST);
    assign w_sof_ack    = r_sof_req && sof_ack_i;

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_DISABLED;
            r_timer    <= '0;
            r_sof_tmr  <= '0;
            r_frame    <= '0;
            r_sof_req  <= 1'b0;
            r_sof_ovr  <= 1'b0;
            r_wake_det <= 1'b0;
            r_oe       <= 1'b0;
            r_dp       <= 1'b0;
            r_dn       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_wake_det <= w_wake && (w_state_nxt == ST_RESUME_K);
            r_sof_ovr  <= w_sof_expire && r_sof_req && !w_sof_ack;

            // Line drive follows the upcoming state so it lines up with link_state_o
            r_oe <= 1'b0;
            r_dp <= 1'b0;
            r_dn <= 1'b0;
            case (w_state_nxt)
                ST_BUS_RESET:   r_oe <= 1'b1;
                ST_RESET_RECOV: begin r_oe <= 1'b1; r_dp <= 1'b1; end
                ST_RESUME_K:    begin r_oe <= 1'b1; r_dn <= 1'b1; end
                ST_RESUME_EOP:  begin r_oe <= 1'b1; r_dp <= (w_timer_nxt >= LP_EOP_J_START); end
                default:        r_oe <= 1'b0;
            endcase

            if (!w_sof_run) begin
                r_sof_tmr <= '0;
                r_sof_req <= 1'b0;
            end else begin
                if (w_sof_expire) begin
                    r_sof_tmr <= '0;
                end else if (us_tick_i) begin
                    r_sof_tmr <= r_sof_tmr + 15'd1;
                end
                if (w_sof_ack) begin
                    r_sof_req <= 1'b0;
                    r_frame   <= r_frame + 11'd1;
                end
                if (w_sof_expire && (!r_sof_req || w_sof_ack)) begin
                    r_sof_req <= 1'b1;
                end
            end

            if ((r_state == ST_RESET_RECOV) && (w_state_nxt == ST_ACTIVE)) begin
                r_frame <= '0;
            end
        end
    end

    assign usb_dp_o      = r_dp;
    assign usb_dn_o      = r_dn;
    assign usb_oe_o      = r_oe;
    assign sof_req_o     = r_sof_req;
    assign frame_num_o   = r_frame;
    assign sof_overrun_o = r_sof_ovr;
    assign wake_det_o    = r_wake_det;
    assign link_state_o  = r_state;

endmodule

// File: tb/tb_usbhost_link_ctrl.sv
// Scoreboard bench for usbhost_link_ctrl: expectations are queued by the stimulus thread
// and consumed by a negedge monitor on state exits, SOF rises, overrun and wake pulses.
module tb_usbhost_link_ctrl;

    localparam int RST  = 20;
    localparam int RCV  = 3;
    localparam int RSM  = 30;
    localparam int SOFP = 10;
    localparam int X    = -1;
    localparam int ALL  = -2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        us_tick = 1'b0;
    logic        enable = 1'b0;
    logic        reset_req = 1'b0;
    logic        suspend_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        dp_in = 1'b1;
    logic        dn_in = 1'b0;
    logic        sof_ack = 1'b0;
    logic        dp_out;
    logic        dn_out;
    logic        oe_out;
    logic        sof_req;
    logic [10:0] frame_num;
    logic        sof_ovr;
    logic        wake_det;
    logic [2:0]  link_state;

    usbhost_link_ctrl #(
        .ResetUs(RST), .RecovUs(RCV), .ResumeUs(RSM), .SofPeriodUs(SOFP), .WakeFiltCycles(32)
    ) dut (
        .clk_48mhz_i(clk), .rst_ni(rst_n), .us_tick_i(us_tick), .enable_i(enable),
        .reset_req_i(reset_req), .suspend_req_i(suspend_req), .resume_req_i(resume_req),
        .usb_dp_i(dp_in), .usb_dn_i(dn_in), .sof_ack_i(sof_ack),
        .usb_dp_o(dp_out), .usb_dn_o(dn_out), .usb_oe_o(oe_out),
        .sof_req_o(sof_req), .frame_num_o(frame_num), .sof_overrun_o(sof_ovr),
        .wake_det_o(wake_det), .link_state_o(link_state)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        int st; int ticks; int cycles; int se0; int jc; int kc; int zc;
    } st_rec_t;
    typedef struct packed { int frame; int ticks; } sof_rec_t;

    st_rec_t  q_st[$];
    sof_rec_t q_sof[$];
    int       q_ovr[$];
    int       q_wake[$];

    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 4;
    int tcnt = 0;
    int sof_target = 0;
    int n_sof = 0;
    bit auto_ack = 1'b0;
    bit mon_on = 1'b0;

    int cur_st = 0;
    int m_ticks = 0, m_cycles = 0, m_se0 = 0, m_j = 0, m_k = 0, m_z = 0;
    int sof_ticks = 0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_field(input string name, input int act, input int exp);
        if (exp != X) check(name, act, (exp == ALL) ? m_cycles : exp);
    endtask

    task automatic close_state();
        st_rec_t r;
        if (q_st.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL state_exit: got exit from state %0d, expected none", cur_st);
        end else begin
            r = q_st.pop_front();
            check("state_id", cur_st, r.st);
            chk_field($sformatf("st%0d_ticks", r.st), m_ticks, r.ticks);
            chk_field($sformatf("st%0d_cycles", r.st), m_cycles, r.cycles);
            chk_field($sformatf("st%0d_se0", r.st), m_se0, r.se0);
            chk_field($sformatf("st%0d_j", r.st), m_j, r.jc);
            chk_field($sformatf("st%0d_k", r.st), m_k, r.kc);
            chk_field($sformatf("st%0d_hiz", r.st), m_z, r.zc);
        end
    endtask

    task automatic push_st(input int st, input int ticks, input int cycles,
                           input int se0, input int jc, input int kc, input int zc);
        st_rec_t r;
        r = '{st: st, ticks: ticks, cycles: cycles, se0: se0, jc: jc, kc: kc, zc: zc};
        q_st.push_back(r);
    endtask

    task automatic push_act();
        push_st(3, X, X, 0, 0, 0, ALL);
    endtask

    task automatic push_reset_seq();
        push_st(1, RST, X, ALL, 0, 0, 0);
        push_st(2, RCV, X, 0, ALL, 0, 0);
    endtask

    task automatic push_resume_seq();
        push_st(5, RSM, X, 0, 0, ALL, 0);
        push_st(6, X, 72, 64, 8, 0, 0);
    endtask

    task automatic push_sof(input int frame, input int ticks);
        sof_rec_t s;
        s = '{frame: frame, ticks: ticks};
        q_sof.push_back(s);
        sof_target++;
    endtask

    task automatic wait_sof();
        int t = 0;
        while ((n_sof < sof_target) && (t < 30000)) begin
            @(posedge clk);
            t++;
        end
        check("sof_wait_count", n_sof, sof_target);
    endtask

    task automatic pulse(input int which);
        @(posedge clk);
        #1;
        reset_req   = (which == 0) || (which == 3);
        suspend_req = (which == 1) || (which == 3);
        resume_req  = (which == 2);
        @(posedge clk);
        #1;
        reset_req   = 1'b0;
        suspend_req = 1'b0;
        resume_req  = 1'b0;
    endtask

    task automatic drive_k(input int n);
        @(posedge clk);
        #1;
        dp_in = 1'b0;
        dn_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        dp_in = 1'b1;
        dn_in = 1'b0;
    endtask

    // 1 us tick source; tick_div = 1 makes every cycle a tick
    initial forever begin
        @(posedge clk);
        #1;
        tcnt    = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
        us_tick = (tcnt == 0);
    end

    // Packet-engine stand-in: acknowledges a request a couple of cycles after it rises
    initial forever begin
        @(negedge clk);
        if (auto_ack && sof_req) begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1 sof_ack = 1'b1;
            @(posedge clk);
            #1 sof_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (int'(link_state) != cur_st) begin
                close_state();
                cur_st   = int'(link_state);
                m_ticks  = 0; m_cycles = 0; m_se0 = 0; m_j = 0; m_k = 0; m_z = 0;
                if (cur_st == 3) sof_ticks = 0;
            end
            m_cycles++;
            if (us_tick) m_ticks++;
            if (!oe_out) m_z++;
            else if (!dp_out && !dn_out) m_se0++;
            else if (dp_out && !dn_out) m_j++;
            else if (!dp_out && dn_out) m_k++;

            if (sof_req && !prev_req) begin
                n_sof++;
                if (q_sof.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sof_rise: got request for frame %0d, expected none", frame_num);
                end else begin
                    sof_rec_t s;
                    s = q_sof.pop_front();
                    check("sof_frame", int'(frame_num), s.frame);
                    check("sof_period_ticks", sof_ticks, s.ticks);
                end
                sof_ticks = 0;
            end
            prev_req = sof_req;
            if (us_tick && (link_state == 3'd3)) sof_ticks++;

            if (sof_ovr) begin
                if (q_ovr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL overrun: got pulse at frame %0d, expected none", frame_num);
                end else begin
                    check("overrun_frame", int'(frame_num), q_ovr.pop_front());
                end
            end

            if (wake_det) begin
                if (q_wake.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wake_det: got pulse in state %0d, expected none", link_state);
                end else begin
                    check("wake_state", int'(link_state), q_wake.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", link_state, 0);
        check("rst_oe", oe_out, 0);
        check("rst_dp", dp_out, 0);
        check("rst_dn", dn_out, 0);
        check("rst_sof_req", sof_req, 0);
        check("rst_frame", frame_num, 0);
        check("rst_overrun", sof_ovr, 0);
        check("rst_wake", wake_det, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Bus reset then SOF cadence with prompt acks
        push_st(0, X, X, 0, 0, 0, ALL);
        push_reset_seq();
        for (int f = 0; f < 3; f++) push_sof(f, SOFP);
        auto_ack = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        pulse(0);
        wait_sof();
        repeat (6) @(posedge clk);

        // Overrun: withhold the ack for 25 ticks
        auto_ack = 1'b0;
        push_sof(3, SOFP);
        wait_sof();
        q_ovr.push_back(3);
        q_ovr.push_back(3);
        repeat (25 * 4) @(posedge clk);
        #1 sof_ack = 1'b1;
        @(posedge clk);
        #1 sof_ack = 1'b0;
        push_sof(4, 3 * SOFP);
        auto_ack = 1'b1;
        wait_sof();
        repeat (6) @(posedge clk);

        // Suspend with a pending request, then host resume
        auto_ack = 1'b0;
        push_sof(5, SOFP);
        wait_sof();
        push_act();
        pulse(1);
        @(negedge clk);
        check("susp_state", link_state, 4);
        check("susp_sof_dropped", sof_req, 0);
        check("susp_frame_kept", frame_num, 5);
        push_st(4, X, X, 0, 0, 0, ALL);
        push_resume_seq();
        push_sof(5, SOFP);
        auto_ack = 1'b1;
        pulse(2);
        wait_sof();
        repeat (6) @(posedge clk);

        // Reset beats suspend in the same cycle
        push_act();
        push_reset_seq();
        push_sof(0, SOFP);
        pulse(3);
        wait_sof();
        repeat (6) @(posedge clk);

        // Reset during ResumeK restarts the full bus-reset timing
        push_act();
        push_st(4, X, X, 0, 0, 0, ALL);
        push_st(5, X, X, 0, 0, ALL, 0);
        push_reset_seq();
        push_sof(0, SOFP);
        pulse(1);
        repeat (5) @(posedge clk);
        pulse(2);
        repeat (40) @(posedge clk);
        pulse(0);
        wait_sof();
        repeat (6) @(posedge clk);

        // Remote wakeup filter
        push_act();
        pulse(1);
        repeat (5) @(posedge clk);
        drive_k(31);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("k31_no_wake", link_state, 4);
        push_st(4, X, X, 0, 0, 0, ALL);
        push_resume_seq();
        push_sof(1, SOFP);
`ifdef USBHOST_REMOTE_WAKE_EN
        q_wake.push_back(5);
        drive_k(32);
`else
        drive_k(32);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("k32_ignored", link_state, 4);
        pulse(2);
`endif
        wait_sof();
        repeat (6) @(posedge clk);

        // Disable drops to Disabled from Active
        push_act();
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(negedge clk);
        check("dis_state", link_state, 0);
        check("dis_sof_req", sof_req, 0);

        // Frame number wrap 2047 -> 0 with a tick every cycle
        push_st(0, X, X, 0, 0, 0, ALL);
        push_reset_seq();
        for (int f = 0; f < 2050; f++) push_sof(f % 2048, SOFP);
        tick_div = 1;
        @(posedge clk);
        #1 enable = 1'b1;
        pulse(0);
        wait_sof();
        repeat (6) @(posedge clk);
        push_act();
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (6) @(posedge clk);

        check("q_state_left", q_st.size(), 0);
        check("q_sof_left", q_sof.size(), 0);
        check("q_overrun_left", q_ovr.size(), 0);
        check("q_wake_left", q_wake.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usbhost_link_ctrl.md
Name: usbhost_link_ctrl

Overview:
Host-side link signalling controller, the far end of the device link-state detector. Drives bus reset (SE0), resume (K plus low-speed EOP) and the idle gap that causes suspend. Generates 1 ms SOF requests with an 11-bit frame number to the host packet engine, and detects device remote-wakeup K while suspended. Sits between host software control registers and the host packet engine / PHY mux.

Parameters:
ResetUs, 10000, bus-reset SE0 duration in us_tick_i periods
RecovUs, 10, idle J after reset before Active (reset recovery guard)
ResumeUs, 20000, host resume K duration in us
SofPeriodUs, 1000, SOF interval in us
WakeFiltCycles, 32, clk cycles of stable K needed to accept remote wakeup

Ports:
clk_48mhz_i  in  1  48 MHz clock
rst_ni  in  1  async active-low reset
us_tick_i  in  1  1-cycle pulse every 1 us
enable_i  in  1  link enable; low forces Disabled
reset_req_i  in  1  pulse: start bus reset
suspend_req_i  in  1  pulse: stop SOFs, enter Suspended
resume_req_i  in  1  pulse: start host resume (valid only in Suspended)
usb_dp_i  in  1  line D+
usb_dn_i  in  1  line D-
sof_ack_i  in  1  packet engine has taken the SOF request
usb_dp_o  out  1  D+ drive value
usb_dn_o  out  1  D- drive value
usb_oe_o  out  1  1 = this block owns the bus
sof_req_o  out  1  level SOF request, held until ack
frame_num_o  out  11  frame number for the pending/next SOF
sof_overrun_o  out  1  pulse: SOF period expired while request still pending
wake_det_o  out  1  pulse: remote wakeup accepted
link_state_o  out  3  current state encoding

Behaviour:
- Reset values: usb_oe_o=0, usb_dp_o=0, usb_dn_o=0, sof_req_o=0, frame_num_o=0, sof_overrun_o=0, wake_det_o=0, state=Disabled(0), all timers 0.
- States/encoding: Disabled=0, BusReset=1, ResetRecov=2, Active=3, Suspended=4, ResumeK=5, ResumeEop=6.
- 15-bit us timer, cleared on every state entry; it increments on us_tick_i. Phase exits occur on the us_tick_i where timer==Param-1, for example ResetUs ticks total.
- enable_i=0: next state Disabled from any state; sof_req_o cleared. enable_i rising: Disabled->Active only via reset_req_i; other requests are ignored in Disabled.
- Request priority in the same cycle: reset_req_i > resume_req_i > suspend_req_i. reset_req_i in any enabled state (including mid-reset) enters BusReset and restarts the timer.
- BusReset: oe=1, dp=0, dn=0 (SE0), for ResetUs. Then ResetRecov: oe=1, J (dp=1, dn=0), for RecovUs. Then Active with frame_num_o=0.
- Active: oe=0 (packet engine owns the bus). SOF timer counts us ticks. On the tick where it equals SofPeriodUs-1, it wraps to 0 and sof_req_o is set.
- SOF handshake: sof_req_o stays high until the cycle sof_ack_i=1 with sof_req_o=1. In the next cycle sof_req_o=0 and frame_num_o increments modulo 2048 (2047->0).
- If the period expires while sof_req_o=1: sof_overrun_o pulses 1 cycle. The request is not duplicated and the frame number is unchanged.
- sof_ack_i without a request is ignored.
- suspend_req_i in Active: enters Suspended. oe=0, and a pending sof_req_o is dropped with frame_num_o unchanged. suspend_req_i in other states is ignored.
- Suspended: resume_req_i enters ResumeK. With remote wakeup accepted (see Optional Feature), wake_det_o pulses in the same cycle as the transition to ResumeK.
- ResumeK: oe=1, K (dp=0, dn=1), for ResumeUs.
- ResumeEop: 64 clk cycles of SE0, then 8 clk cycles of J. Timed in clock cycles, not ticks. Then Active with the SOF timer cleared; the first SOF is requested SofPeriodUs later.
- Outputs usb_*_o and link_state_o are registered and reflect the state one cycle after the transition decision.

Optional Feature:
USBHOST_REMOTE_WAKE_EN
- Defined: in Suspended, a raw K (usb_dp_i=0, usb_dn_i=1) stable for WakeFiltCycles consecutive clocks is accepted. Any non-K sample restarts the count. On acceptance: wake_det_o pulses and the state goes to ResumeK.
- Undefined: usb_dp_i/usb_dn_i are unused, wake_det_o is tied 0, and only resume_req_i leaves Suspended.

Test Plan:
All scenarios use ResetUs=20, RecovUs=3, ResumeUs=30, SofPeriodUs=10.
- Bus reset: enable=1, pulse reset_req_i -> SE0 with oe=1 for exactly 20 ticks, then J for 3 ticks, then state=3 and oe=0.
- SOF cadence: in Active, ack each request 2 cycles after it rises -> sof_req_o rises every 10 ticks; frame_num_o goes 0,1,2,... Preload 2047 -> wraps to 0.
- Overrun: withhold sof_ack_i for 25 ticks -> exactly 2 sof_overrun_o pulses. Frame number is unchanged until the single ack, then +1.
- Suspend/resume: suspend_req_i with a pending request -> sof_req_o drops, state=4. Then resume_req_i -> K for 30 ticks, 64 cycles SE0, 8 cycles J, state=3. The next SOF is 10 ticks later.
- Priority: reset_req_i and suspend_req_i in the same cycle in Active -> BusReset. reset_req_i mid-ResumeK -> BusReset with the timer restarted.
- Remote wake (macro defined): in Suspended, drive K for 31 cycles then J -> no wake. Then K for 32 cycles -> wake_det_o=1 for one cycle, state=5. With the macro undefined, the same stimulus keeps state=4.
